// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: register map, CTRL bit positions and mode encoding.
package led_ctrl_pkg;

    localparam int unsigned RegCtrl   = 32'h00;
    localparam int unsigned RegRate   = 32'h01;
    localparam int unsigned RegBright = 32'h02;
    localparam int unsigned RegData   = 32'h04;

    localparam int unsigned CtrlW      = 4;
    localparam int unsigned CtrlEnable = 0;
    localparam int unsigned CtrlModeLo = 1;
    localparam int unsigned CtrlModeHi = 2;
    localparam int unsigned CtrlInvert = 3;

    localparam int unsigned RateW = 8;

    typedef enum logic [1:0] {
        ModeStatic     = 2'b00,
        ModeBlink      = 2'b01,
        ModeChaseLeft  = 2'b10,
        ModeChaseRight = 2'b11
    } led_mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler and RATE step counter; both are held at zero while run is low.
module led_tick_gen #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] rate,
    input  logic       rate_wr,
    output logic       tick,
    output logic       step
);
    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;

    assign tick = run && (presc_q == PW'(PRESCALE - 1));
    // A RATE write restarts the step sequence, so no step is issued on that cycle.
    assign step = tick && (cnt_q == rate) && !rate_wr;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (!run) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (rate_wr) begin
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = (cnt_q == rate) ? 8'd0 : cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/led_controller.sv
// Memory-mapped LED controller: static, blink and chase modes with register read-back.
// Brightness PWM (BRIGHT register at 0x02) is built only when LED_PWM_EN is defined.
module led_controller #(
    parameter int unsigned NUM_LEDS = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          write_data,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [ADDR_W-1:0]   read_address,
    output logic [7:0]          read_data,
    output logic [NUM_LEDS-1:0] led
);
    import led_ctrl_pkg::*;

    localparam int unsigned NB = NUM_LEDS / 8;

    logic [CtrlW-1:0]    ctrl_q, ctrl_d;
    logic [RateW-1:0]    rate_q, rate_d;
    logic [NUM_LEDS-1:0] data_q, data_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic      ctrl_wr, rate_wr, data_wr, load;
    logic      enable, invert;
    logic      tick, step;
    led_mode_e mode;
    logic [NUM_LEDS-1:0] value;
    logic      gate;

    assign enable = ctrl_q[CtrlEnable];
    assign invert = ctrl_q[CtrlInvert];
    assign mode   = led_mode_e'(ctrl_q[CtrlModeHi:CtrlModeLo]);

    led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .run    (enable),
        .rate   (rate_q),
        .rate_wr(rate_wr),
        .tick   (tick),
        .step   (step)
    );

    logic unused_tick;
    assign unused_tick = tick;

    // Register write decode.
    always_comb begin
        ctrl_wr = write_enable && (write_address == ADDR_W'(RegCtrl));
        rate_wr = write_enable && (write_address == ADDR_W'(RegRate));
        ctrl_d  = ctrl_wr ? write_data[CtrlW-1:0] : ctrl_q;
        rate_d  = rate_wr ? write_data : rate_q;
        data_d  = data_q;
        data_wr = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            if (write_enable && (write_address == ADDR_W'(RegData + i))) begin
                data_d[i*8 +: 8] = write_data;
                data_wr          = 1'b1;
            end
        end
        load = ctrl_wr || data_wr;
    end

    // Pattern and blink phase; a load takes priority over a same-cycle step.
    always_comb begin
        pattern_d = pattern_q;
        if (load) begin
            pattern_d = data_d;
        end else if (step) begin
            unique case (mode)
                ModeChaseLeft:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                ModeChaseRight: pattern_d = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};
                default:        pattern_d = pattern_q;
            endcase
        end

        phase_d = phase_q;
        if (!enable) begin
            phase_d = 1'b1;
        end else if (step && !load && (mode == ModeBlink)) begin
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        unique case (mode)
            ModeStatic: value = data_q;
            ModeBlink:  value = phase_q ? data_q : '0;
            default:    value = pattern_q;
        endcase
        if (invert) begin
            value = ~value;
        end
        led_d = (enable && gate) ? value : '0;
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_q;

    assign bright_d = (write_enable && (write_address == ADDR_W'(RegBright))) ?
                      write_data[PWM_BITS-1:0] : bright_q;
    // Full scale bypasses the comparison so the LEDs stay on every cycle.
    assign gate = (&bright_q) || (pwm_q < bright_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '1;
            pwm_q    <= '0;
        end else begin
            bright_q <= bright_d;
            pwm_q    <= pwm_q + PWM_BITS'(1);
        end
    end
`else
    localparam int unsigned unused_pwm_bits = PWM_BITS;
    assign gate = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            rate_q    <= '0;
            data_q    <= '0;
            pattern_q <= '0;
            phase_q   <= 1'b1;
            led_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rate_q    <= rate_d;
            data_q    <= data_d;
            pattern_q <= pattern_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

    // Combinational read-back; unmapped addresses return zero.
    always_comb begin
        read_data = '0;
        if (read_address == ADDR_W'(RegCtrl)) begin
            read_data = 8'(ctrl_q);
        end else if (read_address == ADDR_W'(RegRate)) begin
            read_data = rate_q;
        end
`ifdef LED_PWM_EN
        else if (read_address == ADDR_W'(RegBright)) begin
            read_data = 8'(bright_q);
        end
`endif
        for (int i = 0; i < int'(NB); i++) begin
            if (read_address == ADDR_W'(RegData + i)) begin
                read_data = data_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: directed scenarios plus randomized register traffic
// checked every cycle against a behavioural model.
module tb_led_controller;
    localparam int N  = 16;
    localparam int P  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   write_data;
    logic         write_enable;
    logic [7:0]   write_address;
    logic [7:0]   read_address;
    logic [7:0]   read_data;
    logic [N-1:0] led;

    always #5 clk = ~clk;

    led_controller #(
        .NUM_LEDS(N),
        .ADDR_W  (8),
        .PRESCALE(P),
        .PWM_BITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .write_enable (write_enable),
        .write_address(write_address),
        .read_address (read_address),
        .read_data    (read_data),
        .led          (led)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0]   m_ctrl;
    int           m_rate;
    logic [N-1:0] m_data, m_pat, m_led;
    bit           m_phase;
    int           m_cyc;    // enabled cycles since counters last held
    int           m_ticks;  // base ticks since last counter clear
    int           m_p;
    int           m_bright;

    logic [7:0] addrs [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_rate = 0; m_data = 0; m_pat = 0; m_led = 0;
        m_phase = 1; m_cyc = 0; m_ticks = 0; m_p = 0; m_bright = 15;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00: return {4'b0, m_ctrl};
            8'h01: return 8'(m_rate);
`ifdef LED_PWM_EN
            8'h02: return 8'(m_bright);
`endif
            8'h04: return m_data[7:0];
            8'h05: return m_data[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs presented before that edge.
    task automatic model_edge();
        bit en, tick, step, load, rate_wr, on;
        int mode;
        logic [N-1:0] val, nd, np;
        if (rst) begin
            model_reset();
            return;
        end
        en      = m_ctrl[0];
        mode    = int'(m_ctrl[2:1]);
        rate_wr = write_enable && write_address == 8'h01;
        tick    = en && (m_cyc % P == P - 1);
        step    = tick && !rate_wr && (m_ticks % (m_rate + 1) == m_rate);

        if (mode == 0)      val = m_data;
        else if (mode == 1) val = m_phase ? m_data : '0;
        else                val = m_pat;
        if (m_ctrl[3]) val = ~val;
        on = 1;
`ifdef LED_PWM_EN
        on = (m_bright == 15) || (m_p < m_bright);
        m_p = (m_p + 1) % 16;
`endif
        m_led = (en && on) ? val : '0;

        nd   = m_data;
        load = 0;
        if (write_enable) begin
            case (write_address)
                8'h00: load = 1;
                8'h04: begin nd[7:0] = write_data;  load = 1; end
                8'h05: begin nd[15:8] = write_data; load = 1; end
                default: ;
            endcase
        end

        if (load)                    np = nd;
        else if (step && mode == 2)  np = (m_pat << 1) | (m_pat >> (N - 1));
        else if (step && mode == 3)  np = (m_pat >> 1) | (m_pat << (N - 1));
        else                         np = m_pat;
        m_pat = np;

        if (!en)                                m_phase = 1;
        else if (step && !load && mode == 1)    m_phase = !m_phase;

        m_cyc = en ? m_cyc + 1 : 0;
        if (!en || rate_wr) m_ticks = 0;
        else if (tick)      m_ticks = m_ticks + 1;

        m_data = nd;
        if (write_enable && write_address == 8'h00) m_ctrl = write_data[3:0];
        if (rate_wr) m_rate = int'(write_data);
`ifdef LED_PWM_EN
        if (write_enable && write_address == 8'h02) m_bright = int'(write_data[3:0]);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        read_address = addrs[$urandom_range(0, 7)];
        #1;
        check("led", led, m_led);
        check("rd", read_data, m_read(read_address));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        cycle();
        write_enable  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        read_address = a;
        #1;
        check(tag, read_data, exp);
    endtask

    initial begin
        int hi;
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7F};
        model_reset();
        rst = 1'b1; write_enable = 1'b0; write_address = 0; write_data = 0; read_address = 0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        check("rst_led", led, 0);
        read_check("rst_ctrl", 8'h00, 8'h00);

        // Static display and read-back
        wr(8'h04, 8'hA5);
        wr(8'h05, 8'h3C);
        wr(8'h00, 8'h01);
        cycle();
        check("static_led", led, 16'h3CA5);
        read_check("rd_data1", 8'h05, 8'h3C);

        // Chase-left from a stopped prescaler
        wr(8'h00, 8'h00);
        wr(8'h04, 8'h01);
        wr(8'h05, 8'h00);
        wr(8'h01, 8'h00);
        wr(8'h00, 8'h05);
        cycle();
        check("chase0", led, 16'h0001);
        idle(4);
        check("chase1", led, 16'h0002);
        idle(4);
        check("chase2", led, 16'h0004);
        idle(52);
        check("chase15", led, 16'h8000);
        idle(4);
        check("chase_wrap", led, 16'h0001);

        // Blink at RATE=1, then inverted
        wr(8'h00, 8'h00);
        wr(8'h04, 8'hF0);
        wr(8'h01, 8'h01);
        wr(8'h00, 8'h03);
        cycle();
        check("blink_on", led, 16'h00F0);
        idle(8);
        check("blink_off", led, 16'h0000);
        idle(8);
        check("blink_on2", led, 16'h00F0);
        wr(8'h00, 8'h00);
        wr(8'h00, 8'h0B);
        cycle();
        check("inv_on", led, 16'hFF0F);
        idle(8);
        check("inv_off", led, 16'hFFFF);

        // DATA write coinciding with a step: load wins, rotation skipped
        wr(8'h00, 8'h00);
        wr(8'h01, 8'h00);
        wr(8'h04, 8'h01);
        wr(8'h05, 8'h00);
        wr(8'h00, 8'h05);
        idle(3);
        wr(8'h04, 8'h10);
        cycle();
        check("load_wins", led, 16'h0010);
        idle(4);
        check("after_load", led, 16'h0020);
        wr(8'h00, 8'h00);
        cycle();
        check("disabled", led, 16'h0000);
        idle(8);

        // Reset mid-chase, then an unmapped write
        wr(8'h00, 8'h05);
        idle(6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_led", led, 0);
        for (int i = 0; i < 8; i++) read_check("rst_mid_rd", addrs[i], 8'h00);
        wr(8'h7F, 8'hFF);
        for (int i = 0; i < 8; i++) read_check("unmapped_rd", addrs[i], 8'h00);

`ifdef LED_PWM_EN
        wr(8'h04, 8'hFF);
        wr(8'h05, 8'hFF);
        wr(8'h02, 8'h04);
        wr(8'h00, 8'h01);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (led[0]) hi++;
        end
        check("pwm_duty4", hi, 4);
        wr(8'h02, 8'h00);
        idle(16);
        wr(8'h02, 8'h0F);
        idle(16);
`else
        hi = 0;
`endif

        // Randomized register traffic
        for (int it = 0; it < 1500; it++) begin
            int r;
            logic [7:0] a, d;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else if (r < 60) begin
                cycle();
            end else begin
                a = addrs[$urandom_range(0, 7)];
                d = 8'($urandom);
                if (a == 8'h01) d = 8'($urandom_range(0, 3));
                if (a == 8'h00 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr(a, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
